// File: rtl/display_scan_mux.sv
// Time-multiplexed N-digit display scanner with a double-buffered digit vector.
// Drives a rotating active-low anode plus the value and index of the active digit.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits above digit 0).
module display_scan_mux #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
    input  logic                          load,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [DIGIT_W-1:0]            one_digit,
    output logic [IDX_W-1:0]              digit_idx,
    output logic                          frame_done,
    output logic                          busy
);

    localparam int unsigned CNT_W  = $clog2(REFRESH_DIV);
    localparam int unsigned DATA_W = NUM_DIGITS * DIGIT_W;
    localparam logic [NUM_DIGITS-1:0] ANODE_RST = {1'b0, {(NUM_DIGITS-1){1'b1}}};

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     shadow_q, shadow_d;
    logic [DATA_W-1:0]     pend_buf_q, pend_buf_d;
    logic                  pend_q, pend_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [DIGIT_W-1:0]    one_digit_q, one_digit_d;
    logic                  frame_done_q, frame_done_d;
    logic                  terminal;
    logic                  boundary;
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_above;
`endif

    // State register: timebase, scan index, double buffer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            pend_buf_q   <= '0;
            pend_q       <= 1'b0;
            anode_q      <= ANODE_RST;
            one_digit_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pend_buf_q   <= pend_buf_d;
            pend_q       <= pend_d;
            anode_q      <= anode_d;
            one_digit_q  <= one_digit_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next state: outputs are derived from next idx/shadow so they move together on one edge.
    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        pend_buf_d   = pend_buf_q;
        pend_d       = pend_q;
        frame_done_d = 1'b0;
        anode_d      = '1;
        one_digit_d  = '0;

        terminal = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        boundary = terminal && (idx_q == IDX_W'(NUM_DIGITS - 1));

        if (terminal) begin
            cnt_d = '0;
            idx_d = boundary ? '0 : idx_q + IDX_W'(1);
        end

        // Swap uses the pending buffer as it was before this edge; a coincident load re-arms pend.
        if (boundary) begin
            frame_done_d = 1'b1;
            if (pend_q) begin
                shadow_d = pend_buf_q;
                pend_d   = 1'b0;
            end
        end
        if (load) begin
            pend_buf_d = digits_in;
            pend_d     = 1'b1;
        end

        one_digit_d = shadow_d[idx_d*DIGIT_W +: DIGIT_W];
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            anode_d[NUM_DIGITS-1-i] = !(idx_d == IDX_W'(i));
        end

`ifdef LEADING_ZERO_BLANK_EN
        // A digit above 0 is blank when it and every more significant digit are zero.
        blank      = '0;
        zero_above = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            zero_above = zero_above && (shadow_d[i*DIGIT_W +: DIGIT_W] == '0);
            blank[i]   = zero_above;
        end
        if (blank[idx_d]) begin
            anode_d = '1;
        end
`endif
    end

    assign anode      = anode_q;
    assign one_digit  = one_digit_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;
    assign busy       = pend_q;

endmodule
